// File: rtl/vl_beat_sequencer.sv
// Walks one vector operation (vl elements of width 8<<vsew bits) as a stream of
// DATA_WIDTH-wide beats with byte offset, tail byte-enables and first/last flags.
module vl_beat_sequencer #(
    parameter int VLEN       = 16384,
    parameter int VLMAX      = VLEN / 8,
    parameter int VL_BITS    = $clog2(VLMAX) + 1,
    parameter int DATA_WIDTH = 64,
    parameter int OFF_BITS   = VL_BITS + 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic [VL_BITS-1:0]     vl_i,
    input  logic [2:0]             vsew_i,
    input  logic                   vill_i,
    output logic                   beat_valid,
    input  logic                   beat_ready,
    output logic [OFF_BITS-1:0]    beat_off,
    output logic [DATA_WIDTH/8-1:0] beat_be,
    output logic                   beat_first,
    output logic                   beat_last,
    output logic                   done
);

    localparam int DB = DATA_WIDTH / 8;
    localparam logic [OFF_BITS-1:0] DB_OFF = OFF_BITS'(DB);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [OFF_BITS-1:0] nbytes_q;
    logic [OFF_BITS-1:0] off_q;
    logic [DB-1:0]       be_q;
    logic                valid_q;
    logic                first_q;
    logic                last_q;
    logic                done_q;

    logic [OFF_BITS-1:0] start_nbytes_d;
    logic                start_empty_d;
    logic [OFF_BITS-1:0] off_d;
    logic [OFF_BITS-1:0] rem_d;

    // Bytes still owed from the beat offset onwards, clipped to one beat.
    function automatic logic [DB-1:0] tail_be(input logic [OFF_BITS-1:0] rem);
        logic [DB-1:0] be;
        for (int i = 0; i < DB; i++) begin
            be[i] = (OFF_BITS'(i) < rem);
        end
        return be;
    endfunction

    function automatic logic is_last(input logic [OFF_BITS-1:0] rem);
        return (rem <= DB_OFF);
    endfunction

    always_comb begin
        start_nbytes_d = {3'b000, vl_i} << vsew_i[1:0];
        start_empty_d  = vill_i || vsew_i[2] || (vl_i == '0);
        off_d          = off_q + DB_OFF;
        rem_d          = nbytes_q - off_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            nbytes_q <= '0;
            off_q    <= '0;
            be_q     <= '0;
            valid_q  <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start_valid) begin
                        nbytes_q <= start_nbytes_d;
                        off_q    <= '0;
                        if (start_empty_d) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            valid_q <= 1'b1;
                            first_q <= 1'b1;
                            last_q  <= is_last(start_nbytes_d);
                            be_q    <= tail_be(start_nbytes_d);
                        end
                    end
                end
                ST_RUN: begin
                    // Outputs only move on acceptance so a stalled beat stays stable.
                    if (beat_ready) begin
                        if (last_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            valid_q <= 1'b0;
                            first_q <= 1'b0;
                            last_q  <= 1'b0;
                            be_q    <= '0;
                            off_q   <= '0;
                        end else begin
                            off_q   <= off_d;
                            first_q <= 1'b0;
                            last_q  <= is_last(rem_d);
                            be_q    <= tail_be(rem_d);
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign start_ready = (state_q == ST_IDLE);
    assign beat_valid  = valid_q;
    assign beat_off    = off_q;
    assign beat_be     = be_q;
    assign beat_first  = first_q;
    assign beat_last   = last_q;
    assign done        = done_q;

endmodule
